// File: rtl/mem_bus_bridge.sv
// Single-outstanding bridge from memcontrol word requests to Wishbone-classic cycles.
// Optional REQ watchdog compiled in with `define BUS_TIMEOUT_EN.
module mem_bus_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   address_in,
    input  logic [DATA_W-1:0]   data_in,
    input  logic                read_req,
    input  logic                write_req,
    output logic [DATA_W-1:0]   data_out,
    output logic                bus_full,
    output logic                done,
    output logic                bus_err,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    output logic [1:0]          state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic              we_q;
    logic              err_q;
    logic              in_req;

    // Byte lanes are always fully enabled, so the low address bits carry no information.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^address_in[1:0];

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            data_out <= '0;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (read_req || write_req) begin
                        adr_q   <= {address_in[ADDR_W-1:2], 2'b00};
                        dat_q   <= data_in;
                        we_q    <= write_req & ~read_req;
                        state   <= S_REQ;
`ifdef BUS_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                    end
                end
                S_REQ: begin
                    // Error dominates a simultaneous ack; data_out only moves on a clean read.
                    if (wb_ack_i || wb_err_i) begin
                        err_q <= wb_err_i;
                        if (!wb_err_i && !we_q)
                            data_out <= wb_dat_i;
                        state <= S_DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_req    = (state == S_REQ);
    assign wb_cyc_o  = in_req;
    assign wb_stb_o  = in_req;
    assign wb_we_o   = in_req & we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = {(DATA_W/8){in_req}};
    assign bus_full  = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign bus_err   = done & err_q;
    assign state_dbg = state;

endmodule
